// File: rtl/sim_axi_pkg.sv
// Shared definitions for the sim_axi_mem AXI4 memory model: burst and response
// encodings, read/write FSM state types, the 4 KB crossing helper and the
// host-memory access calls.
// dci_pmem_read/dci_pmem_write are backed by a sparse package-local memory.
package sim_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_WAIT  = 2'b01,
    R_BURST = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  // Sparse 64-bit word store keyed by 8-byte-aligned address; unwritten words read 0.
  longint unsigned pmem_words [longint unsigned];

  function automatic longint unsigned dci_pmem_read(input longint unsigned raddr,
                                                    input byte unsigned rmask);
    longint unsigned key;
    longint unsigned d;
    key = raddr & ~64'h7;
    d   = 64'h0;
    if (pmem_words.exists(key)) d = pmem_words[key];
    for (int b = 0; b < 8; b++) if (!rmask[b]) d[8*b +: 8] = 8'h00;
    return d;
  endfunction

  function automatic void dci_pmem_write(input longint unsigned waddr,
                                         input longint unsigned wdata,
                                         input byte unsigned wmask);
    longint unsigned key;
    longint unsigned d;
    key = waddr & ~64'h7;
    d   = 64'h0;
    if (pmem_words.exists(key)) d = pmem_words[key];
    for (int b = 0; b < 8; b++) if (wmask[b]) d[8*b +: 8] = wdata[8*b +: 8];
    pmem_words[key] = d;
  endfunction

  // True when an INCR burst starting at page offset 'off' runs past the 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [31:0] first;
    logic [31:0] span;
    first = {20'd0, off} & ~((32'd1 << size) - 32'd1);
    span  = ({24'd0, len} + 32'd1) << size;
    return (first + span) > 32'd4096;
  endfunction

endpackage

// File: rtl/sim_axi_addr_gen.sv
// Next-beat address for one AXI burst (FIXED / INCR / WRAP; reserved type acts as INCR).
// Latency: combinational. Backpressure: none, the owning FSM decides when to advance.
// Ports: addr = current beat, start = burst start, size/len/burst = latched AxSIZE/AxLEN/AxBURST,
// next_addr = address of the following beat (modulo 2^ADDR_W).
module sim_axi_addr_gen
  import sim_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] start,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] nbytes;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_mask;

  assign nbytes     = ONE << size;
  assign incr_addr  = (addr & ~(nbytes - ONE)) + nbytes;
  assign wrap_bytes = ({{(ADDR_W-8){1'b0}}, len} + ONE) << size;
  assign wrap_mask  = wrap_bytes - ONE;

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      // Keep the high bits of the wrap container, take the low bits from the increment.
      BURST_WRAP:  next_addr = (start & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/sim_axi_mem.sv
// AXI4 slave memory model backed by host memory through dci_pmem_read / dci_pmem_write.
// Latency: first R beat RD_LAT cycles after AR handshake, then one beat per cycle; B one cycle after last W.
// Backpressure: rvalid/rdata/rlast and bvalid/bid hold while rready/bready low; all outputs registered.
// Ports: aclk/aresetn (sync, active-low), pc (debug), AR/R read channels, AW/W/B write channels.
// SIM_AXI_MEM_PROTO_CHECK_EN enables protocol checks ($fatal with pc and address).
module sim_axi_mem
  import sim_axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [63:0]         pc,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [ID_W-1:0]     arid,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int LANES  = DATA_W / 64;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(STRB_W - 1);

  rd_state_e         rd_state;
  logic [ADDR_W-1:0] rd_addr, rd_start, rd_next, rd_fetch_addr;
  logic [7:0]        rd_len, rd_beat;
  logic [2:0]        rd_size;
  logic [1:0]        rd_burst;
  logic [3:0]        rd_cnt;
  logic              rd_fetch;

  wr_state_e         wr_state;
  logic [ADDR_W-1:0] wr_addr, wr_start, wr_next;
  logic [7:0]        wr_len, wr_beat;
  logic [2:0]        wr_size;
  logic [1:0]        wr_burst;
  logic              w_hs;

  assign rresp = RESP_OKAY;
  assign bresp = RESP_OKAY;

  sim_axi_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr(rd_addr), .start(rd_start), .size(rd_size), .len(rd_len), .burst(rd_burst),
    .next_addr(rd_next)
  );

  sim_axi_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr(wr_addr), .start(wr_start), .size(wr_size), .len(wr_len), .burst(wr_burst),
    .next_addr(wr_next)
  );

  // A fetch happens when the latency count expires or when a non-final beat is accepted.
  assign rd_fetch      = ((rd_state == R_WAIT) && (rd_cnt == 4'd0)) ||
                         ((rd_state == R_BURST) && rready && (rd_beat != rd_len));
  assign rd_fetch_addr = (rd_state == R_BURST) ? rd_next : rd_addr;
  assign w_hs          = (wr_state == W_DATA) && wvalid && wready;

  function automatic logic [63:0] lane_addr(input logic [ADDR_W-1:0] a, input int k);
    return 64'(a & ~BEAT_MASK) + 64'(8 * k);
  endfunction

  // Read path
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rd_addr  <= '0;
      rd_start <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_beat  <= '0;
      rd_cnt   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready  <= 1'b0;
            rid      <= arid;
            rd_addr  <= araddr;
            rd_start <= araddr;
            rd_len   <= arlen;
            rd_size  <= arsize;
            rd_burst <= arburst;
            rd_cnt   <= 4'(RD_LAT - 1);
            rd_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == 4'd0) begin
            rvalid   <= 1'b1;
            rlast    <= (rd_len == 8'd0);
            rd_beat  <= 8'd0;
            rd_state <= R_BURST;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_BURST: begin
          if (rready) begin
            if (rd_beat == rd_len) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              rd_beat <= rd_beat + 8'd1;
              rd_addr <= rd_next;
              rlast   <= ((rd_beat + 8'd1) == rd_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write path
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      wr_addr  <= '0;
      wr_start <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_beat  <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
            wr_addr  <= awaddr;
            wr_start <= awaddr;
            wr_len   <= awlen;
            wr_size  <= awsize;
            wr_burst <= awburst;
            wr_beat  <= 8'd0;
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (wr_beat == wr_len) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              wr_state <= W_RESP;
            end else begin
              wr_beat <= wr_beat + 8'd1;
              wr_addr <= wr_next;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Memory port: read fetch is issued before the write commit so a same-edge
  // read of the same address returns the pre-write data.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdata <= '0;
    end else begin
      if (rd_fetch) begin
        for (int k = 0; k < LANES; k++)
          rdata[64*k +: 64] <= dci_pmem_read(lane_addr(rd_fetch_addr, k), 8'hFF);
      end
      if (w_hs) begin
        for (int k = 0; k < LANES; k++)
          dci_pmem_write(lane_addr(wr_addr, k), wdata[64*k +: 64], wstrb[8*k +: 8]);
      end
    end
  end

`ifdef SIM_AXI_MEM_PROTO_CHECK_EN
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      if (arvalid && arready) begin
        if (arsize > MAX_SIZE)
          $fatal(1, "sim_axi_mem: arsize too large pc=%h addr=%h", pc, araddr);
        if (arburst == 2'b11)
          $fatal(1, "sim_axi_mem: reserved arburst pc=%h addr=%h", pc, araddr);
        if ((arburst == BURST_WRAP) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
          $fatal(1, "sim_axi_mem: illegal WRAP arlen pc=%h addr=%h", pc, araddr);
        if ((arburst == BURST_INCR) && crosses_4k(araddr[11:0], arlen, arsize))
          $fatal(1, "sim_axi_mem: read crosses 4KB pc=%h addr=%h", pc, araddr);
      end
      if (awvalid && awready) begin
        if (awsize > MAX_SIZE)
          $fatal(1, "sim_axi_mem: awsize too large pc=%h addr=%h", pc, awaddr);
        if (awburst == 2'b11)
          $fatal(1, "sim_axi_mem: reserved awburst pc=%h addr=%h", pc, awaddr);
        if ((awburst == BURST_WRAP) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
          $fatal(1, "sim_axi_mem: illegal WRAP awlen pc=%h addr=%h", pc, awaddr);
        if ((awburst == BURST_INCR) && crosses_4k(awaddr[11:0], awlen, awsize))
          $fatal(1, "sim_axi_mem: write crosses 4KB pc=%h addr=%h", pc, awaddr);
      end
      if (w_hs && (wlast != (wr_beat == wr_len)))
        $fatal(1, "sim_axi_mem: wlast mismatch pc=%h addr=%h", pc, wr_addr);
    end
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^{pc, wlast};
`endif

endmodule

// File: tb/tb_sim_axi_mem.sv
// Directed self-checking bench for sim_axi_mem (DATA_W=64, RD_LAT=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sim_axi_mem;
  import sim_axi_pkg::*;

  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int RD_LAT = 3;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [63:0]       pc;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [ID_W-1:0]   arid, awid, rid, bid;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [7:0]        wstrb;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [63:0] exp_incr [4];
  logic [63:0] exp_wrap [4];

  sim_axi_mem #(.DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .aclk(aclk), .aresetn(aresetn), .pc(pc),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Returns with the bench at the falling edge after the AR handshake edge.
  task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    araddr = addr; arid = id; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 40) begin @(negedge aclk); n++; end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    awaddr = addr; awid = id; awlen = len; awsize = 3'd3; awburst = BURST_INCR; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 40) begin @(negedge aclk); n++; end
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  // Counts falling edges after the AR handshake until rvalid; bounded.
  task automatic wait_rvalid(output int l);
    l = 0;
    while (rvalid !== 1'b1 && l < 40) begin @(negedge aclk); l++; end
  endtask

  initial begin
    aresetn = 1'b0; pc = 64'h8000_1234;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    exp_incr = '{64'h0101_0101_0000_0010, 64'h0202_0202_0000_0018,
                 64'h0303_0303_0000_0020, 64'h0404_0404_0000_0028};
    exp_wrap = '{64'h0202_0202_0000_0018, 64'h1111_2222_3333_4444,
                 64'h0505_0505_0000_0008, 64'h0101_0101_0000_0010};

    dci_pmem_write(64'h8000_0000, 64'h1111_2222_3333_4444, 8'hFF);
    dci_pmem_write(64'h8000_0008, 64'h0505_0505_0000_0008, 8'hFF);
    dci_pmem_write(64'h8000_0010, 64'h0101_0101_0000_0010, 8'hFF);
    dci_pmem_write(64'h8000_0018, 64'h0202_0202_0000_0018, 8'hFF);
    dci_pmem_write(64'h8000_0020, 64'h0303_0303_0000_0020, 8'hFF);
    dci_pmem_write(64'h8000_0028, 64'h0404_0404_0000_0028, 8'hFF);
    dci_pmem_write(64'h8000_0100, 64'hFFEE_DDCC_BBAA_9988, 8'hFF);
    dci_pmem_write(64'h8000_0108, 64'h7766_5544_3322_1100, 8'hFF);

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_ctrl", 64'({arready, awready, wready, rvalid, bvalid, rlast, rid, bid, rresp, bresp}), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk1("rel_arready", arready, 1'b1);
    chk1("rel_awready", awready, 1'b1);

    // Single read, latency RD_LAT
    rready = 1'b1;
    ar_send(32'h8000_0000, 4'd3, 8'd0, BURST_INCR);
    chk1("t1_arready_drop", arready, 1'b0);
    wait_rvalid(lat);
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_rdata", rdata, 64'h1111_2222_3333_4444);
    chk1("t1_rlast", rlast, 1'b1);
    chk("t1_rid", 64'(rid), 64'd3);
    @(negedge aclk);
    chk1("t1_rvalid_done", rvalid, 1'b0);
    chk1("t1_arready_back", arready, 1'b1);

    // INCR read with rready toggling every other cycle
    rready = 1'b0;
    ar_send(32'h8000_0010, 4'd2, 8'd3, BURST_INCR);
    wait_rvalid(lat);
    chk("t2_latency", 64'(lat), 64'd3);
    for (int b = 0; b < 4; b++) begin
      chk("t2_rdata", rdata, exp_incr[b]);
      chk1("t2_rlast", rlast, b == 3);
      @(negedge aclk);
      chk1("t2_hold_rvalid", rvalid, 1'b1);
      chk("t2_hold_rdata", rdata, exp_incr[b]);
      chk1("t2_hold_rlast", rlast, b == 3);
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
    end
    chk1("t2_rvalid_done", rvalid, 1'b0);
    chk1("t2_arready_back", arready, 1'b1);

    // WRAP read, bubble-free with rready high
    rready = 1'b1;
    ar_send(32'h8000_0018, 4'd4, 8'd3, BURST_WRAP);
    wait_rvalid(lat);
    chk("t3_latency", 64'(lat), 64'd3);
    for (int b = 0; b < 4; b++) begin
      chk1("t3_rvalid", rvalid, 1'b1);
      chk("t3_rdata", rdata, exp_wrap[b]);
      chk1("t3_rlast", rlast, b == 3);
      @(negedge aclk);
    end
    chk1("t3_rvalid_done", rvalid, 1'b0);
    chk1("t3_arready_back", arready, 1'b1);

    // Two-beat write with byte strobes
    aw_send(32'h8000_0100, 4'd5, 8'd1);
    chk1("t4_wready_rise", wready, 1'b1);
    chk1("t4_awready_drop", awready, 1'b0);
    wvalid = 1'b1; wdata = 64'hAAAA_AAAA_1234_5678; wstrb = 8'h0F; wlast = 1'b0;
    @(negedge aclk);
    chk1("t4_bvalid_early", bvalid, 1'b0);
    wdata = 64'h8765_4321_BBBB_BBBB; wstrb = 8'hF0; wlast = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    chk1("t4_bvalid", bvalid, 1'b1);
    chk("t4_bid", 64'(bid), 64'd5);
    chk("t4_bresp", 64'(bresp), 64'd0);
    chk1("t4_wready_drop", wready, 1'b0);
    @(negedge aclk);
    chk1("t4_bvalid_hold", bvalid, 1'b1);
    chk("t4_bid_hold", 64'(bid), 64'd5);
    bready = 1'b1;
    @(negedge aclk);
    chk1("t4_bvalid_done", bvalid, 1'b0);
    chk1("t4_awready_back", awready, 1'b1);
    ar_send(32'h8000_0100, 4'd6, 8'd1, BURST_INCR);
    wait_rvalid(lat);
    chk("t4_rb0", rdata, 64'hFFEE_DDCC_1234_5678);
    chk("t4_rb_rid", 64'(rid), 64'd6);
    @(negedge aclk);
    chk("t4_rb1", rdata, 64'h8765_4321_3322_1100);
    chk1("t4_rb1_rlast", rlast, 1'b1);
    @(negedge aclk);

    // Concurrent read and write to distinct addresses
    chk("t5_ready_pre", 64'({arready, awready}), 64'd3);
    araddr = 32'h8000_0020; arid = 4'd1; arlen = 8'd0; arsize = 3'd3; arburst = BURST_INCR; arvalid = 1'b1;
    awaddr = 32'h8000_0200; awid = 4'd2; awlen = 8'd0; awsize = 3'd3; awburst = BURST_INCR; awvalid = 1'b1;
    wvalid = 1'b1; wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'hFF; wlast = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    chk1("t5_wready", wready, 1'b1);
    chk1("t5_arready_drop", arready, 1'b0);
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    chk1("t5_bvalid", bvalid, 1'b1);
    chk("t5_bid", 64'(bid), 64'd2);
    @(negedge aclk);
    chk1("t5_bvalid_done", bvalid, 1'b0);
    chk1("t5_awready_back", awready, 1'b1);
    chk1("t5_rvalid_early", rvalid, 1'b0);
    @(negedge aclk);
    chk1("t5_rvalid", rvalid, 1'b1);
    chk("t5_rdata", rdata, 64'h0303_0303_0000_0020);
    chk("t5_rid", 64'(rid), 64'd1);
    @(negedge aclk);
    chk1("t5_arready_back", arready, 1'b1);
    ar_send(32'h8000_0200, 4'd7, 8'd0, BURST_INCR);
    wait_rvalid(lat);
    chk("t5_rb", rdata, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge aclk);

    // Reset during beat 1 of a 3-beat read
    ar_send(32'h8000_0010, 4'd9, 8'd2, BURST_INCR);
    wait_rvalid(lat);
    chk("t6_beat0", rdata, 64'h0101_0101_0000_0010);
    @(negedge aclk);
    chk("t6_beat1", rdata, 64'h0202_0202_0000_0018);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("t6_rst_ctrl", 64'({arready, awready, wready, rvalid, bvalid, rlast, rid, bid, rresp, bresp}), 64'd0);
    chk("t6_rst_rdata", rdata, 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk1("t6_arready_rel", arready, 1'b1);
    chk1("t6_rvalid_rel", rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
